// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the score display controller.
package score_display_ctrl_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Judgement codes coming from the rhythm datapath.
    typedef enum logic [1:0] {
        ACC_NONE    = 2'b00,
        ACC_PERFECT = 2'b01,
        ACC_GOOD    = 2'b10,
        ACC_MISS    = 2'b11
    } acc_e;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        SHIFT  = 2'b10,
        COMMIT = 2'b11
    } state_e;

    // Double-dabble digit correction applied before each left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] digit);
        return (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;
    endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Datapath-facing inputs and display-facing outputs of the score display controller.
interface score_display_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    localparam int DW = score_display_ctrl_pkg::BCD_W * DIGITS;

    logic             tick;
    logic [WIDTH-1:0] score_in;
    logic [WIDTH-1:0] combo_in;
    logic [1:0]       accuracy_in;
    logic [DW-1:0]    score_bcd;
    logic [DW-1:0]    combo_bcd;
    logic [DW-1:0]    max_bcd;
    logic [1:0]       acc_hold;
    logic             busy;

    // Producer side: drives beat ticks and datapath values, reads the display.
    modport master (
        output tick, score_in, combo_in, accuracy_in,
        input  score_bcd, combo_bcd, max_bcd, acc_hold, busy
    );

    // Controller side.
    modport slave (
        input  tick, score_in, combo_in, accuracy_in,
        output score_bcd, combo_bcd, max_bcd, acc_hold, busy
    );
endinterface

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per step.
module bin2bcd_seq
    import score_display_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic [WIDTH-1:0]          bin_in,
    output logic [BCD_W*DIGITS-1:0]   bcd_step
);
    localparam int DW = BCD_W * DIGITS;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    adj;

    // Digit correction, the value after one more step, and the next register state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        adj     = acc_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            adj[i*BCD_W +: BCD_W] = dabble_adjust(acc_q[i*BCD_W +: BCD_W]);
        end
        bcd_step = {adj[DW-2:0], shreg_q[WIDTH-1]};
        if (load) begin
            shreg_d = bin_in;
            acc_d   = '0;
        end else if (step) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            acc_d   = bcd_step;
        end
    end

    // Shifter and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            acc_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before this edge.
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: BCD conversion of score/combo/max-combo and timed accuracy hold.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter int HOLD_TICKS = 4
) (
    input logic                clk,
    input logic                rst,
    score_display_ctrl_if.slave bus
);
    localparam int DW     = BCD_W * DIGITS;
    localparam int SCNT_W = $clog2(WIDTH + 1);
    localparam int HCNT_W = $clog2(HOLD_TICKS + 1);

    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0] LAST_STEP = SCNT_W'(WIDTH - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_TICKS);

    // Sampled inputs, max-combo record and the values most recently snapshotted.
    logic [WIDTH-1:0]  score_q, score_d, combo_q, combo_d, max_q, max_d;
    logic [WIDTH-1:0]  last_score_q, last_score_d, last_combo_q, last_combo_d;
    logic [WIDTH-1:0]  last_max_q, last_max_d;

    // Conversion sequencer.
    state_e            state_q, state_d;
    logic [SCNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic [DW-1:0]     score_bcd_q, score_bcd_d, combo_bcd_q, combo_bcd_d;
    logic [DW-1:0]     max_bcd_q, max_bcd_d;

    // Accuracy hold.
    acc_e              acc_hold_q, acc_hold_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        acc_prev_q, acc_prev_d;

    logic              change;
    logic              conv_load, conv_step;
    logic [DW-1:0]     score_step, combo_step, max_step;
    logic [1:0]        acc_in;

    assign conv_load = (state_q == LOAD);
    assign conv_step = (state_q == SHIFT);
    assign change    = (score_q != last_score_q) || (combo_q != last_combo_q) ||
                       (max_q != last_max_q);
    assign acc_in    = bus.accuracy_in;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_score_conv (
        .clk(clk), .rst(rst), .load(conv_load), .step(conv_step),
        .bin_in(score_q), .bcd_step(score_step)
    );

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_combo_conv (
        .clk(clk), .rst(rst), .load(conv_load), .step(conv_step),
        .bin_in(combo_q), .bcd_step(combo_step)
    );

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_max_conv (
        .clk(clk), .rst(rst), .load(conv_load), .step(conv_step),
        .bin_in(max_q), .bcd_step(max_step)
    );

    // Next-state logic: sampling, max record, conversion sequencing and accuracy hold.
    always_comb begin
        score_d      = bus.score_in;
        combo_d      = bus.combo_in;
        max_d        = (combo_q > max_q) ? combo_q : max_q;
        last_score_d = last_score_q;
        last_combo_d = last_combo_q;
        last_max_d   = last_max_q;
        state_d      = state_q;
        shift_cnt_d  = shift_cnt_q;
        pending_d    = pending_q;
        score_bcd_d  = score_bcd_q;
        combo_bcd_d  = combo_bcd_q;
        max_bcd_d    = max_bcd_q;
        acc_hold_d   = acc_hold_q;
        hold_cnt_d   = hold_cnt_q;
        acc_prev_d   = acc_in;

        unique case (state_q)
            IDLE: begin
                if (change || pending_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // The converters take this same snapshot on this edge.
                last_score_d = score_q;
                last_combo_d = combo_q;
                last_max_d   = max_q;
                pending_d    = 1'b0;
                shift_cnt_d  = '0;
                state_d      = SHIFT;
            end
            SHIFT: begin
                shift_cnt_d = shift_cnt_q + SCNT_ONE;
                if (shift_cnt_q == LAST_STEP) begin
                    // Results are published on the edge that completes the last shift,
                    // so the display holds them from the first COMMIT clock onward.
                    score_bcd_d = score_step;
                    combo_bcd_d = combo_step;
                    max_bcd_d   = max_step;
                    state_d     = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A change seen after the snapshot was taken forces one more pass.
        if ((state_q == SHIFT || state_q == COMMIT) && change) begin
            pending_d = 1'b1;
        end

        // A newly arriving nonzero code wins over a coincident tick.
        if (acc_in != ACC_NONE && acc_in != acc_prev_q) begin
            acc_hold_d = acc_e'(acc_in);
            hold_cnt_d = HOLD_LOAD;
        end else if (bus.tick && hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HCNT_ONE;
            if (hold_cnt_q == HCNT_ONE) begin
                acc_hold_d = ACC_NONE;
            end
        end
    end

    assign busy_d = (state_d != IDLE);

    // All controller state; reset aborts any conversion without committing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q      <= '0;
            combo_q      <= '0;
            max_q        <= '0;
            last_score_q <= '0;
            last_combo_q <= '0;
            last_max_q   <= '0;
            state_q      <= IDLE;
            shift_cnt_q  <= '0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            score_bcd_q  <= '0;
            combo_bcd_q  <= '0;
            max_bcd_q    <= '0;
            acc_hold_q   <= ACC_NONE;
            hold_cnt_q   <= '0;
            acc_prev_q   <= '0;
        end else begin
            score_q      <= score_d;
            combo_q      <= combo_d;
            max_q        <= max_d;
            last_score_q <= last_score_d;
            last_combo_q <= last_combo_d;
            last_max_q   <= last_max_d;
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            score_bcd_q  <= score_bcd_d;
            combo_bcd_q  <= combo_bcd_d;
            max_bcd_q    <= max_bcd_d;
            acc_hold_q   <= acc_hold_d;
            hold_cnt_q   <= hold_cnt_d;
            acc_prev_q   <= acc_prev_d;
        end
    end

    assign bus.score_bcd = score_bcd_q;
    assign bus.combo_bcd = combo_bcd_q;
    assign bus.max_bcd   = max_bcd_q;
    assign bus.acc_hold  = acc_hold_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl with a decimal reference model.
module tb_score_display_ctrl;
    import score_display_ctrl_pkg::*;

    localparam int WIDTH      = 8;
    localparam int DIGITS     = 3;
    localparam int HOLD_TICKS = 4;
    localparam int DW         = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_display_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    score_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int model_max = 0;
    bit seen_score [0:999];
    bit seen_combo [0:999];
    int score_commits [$];
    logic [DW-1:0] prev_score = '0;
    logic [DW-1:0] prev_combo = '0;

    // Decimal digits of v by plain arithmetic.
    function automatic logic [DW-1:0] to_bcd(input int v);
        return DW'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [DW-1:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [DW-1:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    task automatic drive_score(input int v);
        bus.score_in = v[7:0];
        seen_score[v] = 1'b1;
    endtask

    task automatic drive_combo(input int v);
        bus.combo_in = v[7:0];
        seen_combo[v] = 1'b1;
        if (v > model_max) model_max = v;
    endtask

    // Wait until the controller has been idle for three samples in a row (bounded).
    task automatic wait_idle();
        int quiet = 0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 200 && quiet < 3; n++) begin
            @(negedge clk);
            quiet = bus.busy ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            checks++; errors++;
            $display("FAIL idle_timeout busy still %b after 200 clks, required 0", bus.busy);
        end
    endtask

    // Displayed values must always be a complete value that was actually driven.
    always @(negedge clk) begin
        if (!rst && bus.score_bcd !== prev_score) begin
            checks++;
            if (!bcd_ok(bus.score_bcd) || !seen_score[from_bcd(bus.score_bcd)]) begin
                errors++;
                $display("FAIL score_partial got %h, required a driven score", bus.score_bcd);
            end
            score_commits.push_back(from_bcd(bus.score_bcd));
        end
        if (!rst && bus.combo_bcd !== prev_combo) begin
            checks++;
            if (!bcd_ok(bus.combo_bcd) || !seen_combo[from_bcd(bus.combo_bcd)]) begin
                errors++;
                $display("FAIL combo_partial got %h, required a driven combo", bus.combo_bcd);
            end
        end
        prev_score = bus.score_bcd;
        prev_combo = bus.combo_bcd;
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.tick = 1'b0;
        bus.accuracy_in = 2'b00;
        bus.score_in = '0;
        bus.combo_in = '0;
        seen_score[0] = 1'b1;
        seen_combo[0] = 1'b1;
        model_max = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.score_bcd, bus.combo_bcd, bus.max_bcd, bus.acc_hold, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h/%h/%b/%b, required all 0",
                     bus.score_bcd, bus.combo_bcd, bus.max_bcd, bus.acc_hold, bus.busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.score_bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle busy %b score %h, required 0 and 000", bus.busy, bus.score_bcd);
        end
    endtask

    task automatic test_latency();
        int busy_cycles = 0;
        int first_busy = -1;
        drive_score(173);
        drive_combo(42);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = k;
            end
            if (k == 10) begin
                checks++;
                if (bus.score_bcd !== 12'h000) begin
                    errors++;
                    $display("FAIL latency_early score %h at clk 10, required 000", bus.score_bcd);
                end
            end
            if (k == 11) begin
                checks++;
                if (bus.score_bcd !== 12'h173 || bus.combo_bcd !== 12'h042 || bus.max_bcd !== 12'h042) begin
                    errors++;
                    $display("FAIL latency_values got %h/%h/%h at clk 11, required 173/042/042",
                             bus.score_bcd, bus.combo_bcd, bus.max_bcd);
                end
            end
        end
        checks++;
        if (busy_cycles != 10 || first_busy != 2) begin
            errors++;
            $display("FAIL busy_window %0d clks from clk %0d, required 10 from clk 2",
                     busy_cycles, first_busy);
        end
    endtask

    task automatic test_extremes();
        drive_score(255);
        wait_idle();
        checks++;
        if (bus.score_bcd !== 12'h255) begin
            errors++;
            $display("FAIL score_max got %h, required 255", bus.score_bcd);
        end
        drive_score(0);
        wait_idle();
        checks++;
        if (bus.score_bcd !== 12'h000) begin
            errors++;
            $display("FAIL score_zero got %h, required 000", bus.score_bcd);
        end
    endtask

    task automatic test_max_hold();
        drive_combo(0);
        wait_idle();
        drive_combo(7);
        wait_idle();
        checks++;
        if (bus.max_bcd !== 12'h042 || bus.combo_bcd !== 12'h007) begin
            errors++;
            $display("FAIL max_record max %h combo %h, required 042 and 007", bus.max_bcd, bus.combo_bcd);
        end
    endtask

    task automatic test_back_to_back();
        score_commits.delete();
        drive_score(10);
        repeat (4) @(negedge clk);
        drive_score(11);
        repeat (2) @(negedge clk);
        drive_score(12);
        wait_idle();
        checks++;
        if (score_commits.size() != 2 || score_commits[0] != 10 || score_commits[1] != 12) begin
            errors++;
            $display("FAIL collapse commits %p, required '{10, 12}", score_commits);
        end
    endtask

    task automatic pulse_tick(input logic [1:0] acc_with_tick);
        bus.tick = 1'b1;
        bus.accuracy_in = acc_with_tick;
        @(negedge clk);
        bus.tick = 1'b0;
        bus.accuracy_in = (acc_with_tick == 2'b10) ? 2'b10 : 2'b00;
    endtask

    task automatic test_accuracy();
        logic [1:0] exp_hold [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
        // Single-clock perfect flash held for exactly HOLD_TICKS ticks.
        bus.accuracy_in = 2'b01;
        @(negedge clk);
        bus.accuracy_in = 2'b00;
        checks++;
        if (bus.acc_hold !== 2'b01) begin
            errors++;
            $display("FAIL acc_capture got %b, required 01", bus.acc_hold);
        end
        for (int t = 0; t < HOLD_TICKS; t++) begin
            repeat (2) @(negedge clk);
            pulse_tick(2'b00);
            checks++;
            if (bus.acc_hold !== exp_hold[t]) begin
                errors++;
                $display("FAIL acc_expire tick %0d got %b, required %b", t + 1, bus.acc_hold, exp_hold[t]);
            end
        end
        // Miss arriving together with tick 2 wins and restarts the hold.
        bus.accuracy_in = 2'b01;
        @(negedge clk);
        bus.accuracy_in = 2'b00;
        repeat (2) @(negedge clk);
        pulse_tick(2'b00);
        repeat (2) @(negedge clk);
        pulse_tick(2'b11);
        checks++;
        if (bus.acc_hold !== 2'b11) begin
            errors++;
            $display("FAIL acc_override got %b, required 11", bus.acc_hold);
        end
        for (int t = 0; t < HOLD_TICKS; t++) begin
            repeat (2) @(negedge clk);
            pulse_tick(2'b00);
            checks++;
            if (bus.acc_hold !== ((t < HOLD_TICKS - 1) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL acc_reload tick %0d got %b", t + 1, bus.acc_hold);
            end
        end
        // A steady good code expires and does not come back.
        bus.accuracy_in = 2'b10;
        for (int t = 0; t < HOLD_TICKS + 2; t++) begin
            repeat (2) @(negedge clk);
            pulse_tick(2'b10);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.acc_hold !== 2'b00) begin
            errors++;
            $display("FAIL acc_steady got %b, required 00", bus.acc_hold);
        end
        bus.accuracy_in = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            drive_score(int'($urandom_range(0, 255)));
            drive_combo(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 12)) @(negedge clk);
                drive_score(int'($urandom_range(0, 255)));
                drive_combo(int'($urandom_range(0, 255)));
            end
            wait_idle();
            checks++;
            if (bus.score_bcd !== to_bcd(int'(bus.score_in)) ||
                bus.combo_bcd !== to_bcd(int'(bus.combo_in)) ||
                bus.max_bcd !== to_bcd(model_max)) begin
                errors++;
                $display("FAIL random_%0d got %h/%h/%h, required %h/%h/%h", it,
                         bus.score_bcd, bus.combo_bcd, bus.max_bcd,
                         to_bcd(int'(bus.score_in)), to_bcd(int'(bus.combo_in)), to_bcd(model_max));
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_score(99);
        drive_combo(int'(bus.combo_in) == 99 ? 98 : 99);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup busy %b, required 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.score_bcd, bus.combo_bcd, bus.max_bcd, bus.acc_hold, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_async got %h/%h/%h/%b/%b, required all 0",
                     bus.score_bcd, bus.combo_bcd, bus.max_bcd, bus.acc_hold, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_max = int'(bus.combo_in);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.score_bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_no_commit busy %b score %h, required 0 and 000", bus.busy, bus.score_bcd);
        end
        wait_idle();
        checks++;
        if (bus.score_bcd !== 12'h099 || bus.max_bcd !== to_bcd(model_max)) begin
            errors++;
            $display("FAIL reset_recover score %h max %h, required 099 and %h",
                     bus.score_bcd, bus.max_bcd, to_bcd(model_max));
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_extremes();
        test_max_hold();
        test_back_to_back();
        test_accuracy();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
